instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter TEXT_BASE, default 32'h00400000, byte address of the first .text location.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of instruction-memory locations.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_addr  input  32  byte fetch address from the datapath (insMemAddress).
REQ-006 SHALL have port cpu_read  input  1  fetch request from the datapath (insMemRead).
REQ-007 SHALL have port ins_data  output  32  fetched instruction word to the datapath (insReadValue).
REQ-008 SHALL have port ins_valid  output  1  one-cycle pulse marking ins_data updated for the accepted address.
REQ-009 SHALL have port stall  output  1  datapath must hold pc while high.
REQ-010 SHALL have port fault  output  1  one-cycle pulse for an illegal fetch address.
REQ-011 SHALL have port mem_addr  output  10  location index into instruction memory.
REQ-012 SHALL have port mem_req  output  1  memory read request, held until mem_ack.
REQ-013 SHALL have port mem_ack  input  1  memory read completion; mem_rdata valid in the same cycle.
REQ-014 SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-015 SHALL compute offset = cpu_addr - TEXT_BASE; mem_addr = offset[9:0], no shift (memory is indexed by byte offset).
REQ-016 SHALL treat the address as illegal if cpu_addr < TEXT_BASE, offset >= MEM_WORDS, or cpu_addr[1:0] != 0.
REQ-017 SHALL implement states IDLE, REQ, RESP, FAULT.
REQ-018 SHALL, in IDLE with cpu_read=1, latch cpu_addr; illegal -> FAULT; cache hit -> RESP; otherwise -> REQ.
REQ-019 SHALL hold mem_req=1 and mem_addr stable throughout REQ; on mem_ack, register mem_rdata into ins_data and go to RESP.
REQ-020 SHALL drive ins_valid=1 only in RESP, for exactly one cycle, then return to IDLE.
REQ-021 SHALL drive fault=1 only in FAULT, for exactly one cycle; ins_data is unchanged; FAULT -> IDLE.
REQ-022 SHALL drive stall = (state==REQ) | (state==IDLE & cpu_read) | (state==FAULT).
REQ-023 SHALL give hit latency 1 cycle and miss latency 2 + N cycles, where N is the number of cycles mem_ack stays low after mem_req rises.
REQ-024 SHALL ignore cpu_addr and cpu_read changes outside IDLE; a started transaction always completes and pulses ins_valid.
REQ-025 SHALL hold ins_data stable between fetch completions.
REQ-026 SHALL ignore mem_ack outside REQ.

Reset
REQ-027 SHALL, while reset=1 (asynchronously), force state=IDLE, ins_data=0, ins_valid=0, fault=0, mem_req=0, mem_addr=0, and clear all cache valid bits.
REQ-028 SHALL abandon an in-flight REQ on reset; a late mem_ack is then ignored.
REQ-029 SHALL drive stall combinationally per REQ-022 during reset (IDLE state).

Configuration
REQ-030 SHALL include, when ICACHE_EN is defined, a 4-entry direct-mapped cache: index offset[3:2], tag offset[9:4], filled on every mem_ack in REQ.
REQ-031 SHALL, when ICACHE_EN is undefined, contain no cache storage; every legal fetch takes the miss path.

Structure
REQ-032 SHALL take from package mips_fetch_pkg: the state enumeration, the default TEXT_BASE constant, and the cache index/tag widths.
REQ-033 SHALL place the cache tag/valid/data arrays in sub-module icache_array, instantiated only under ICACHE_EN.

Verification
REQ-034 SHALL cover: reset, cpu_addr=0x00400000 read, mem_ack two cycles after mem_req, mem_rdata=0x24080064 -> mem_addr=0x000, ins_data=0x24080064, ins_valid pulses at cycle 4, stall low that cycle.
REQ-035 SHALL cover: with ICACHE_EN, refetch 0x00400000 -> ins_valid one cycle later, mem_req never asserted; without it -> full miss path.
REQ-036 SHALL cover: cpu_addr=0x00400002, then 0x003FFFFC, then 0x00400400 -> fault pulses for each, mem_req stays 0, ins_data unchanged.
REQ-037 SHALL cover: reset asserted in REQ -> mem_req, ins_valid, and stall drop immediately; after release, 0x00400000 misses again.
REQ-038 SHALL cover: with ICACHE_EN, fetch 0x00400000, 0x00400010 (same index), then 0x00400000 -> third fetch misses with mem_addr=0x000.
REQ-039 SHALL cover: cpu_addr changed to 0x00400008 mid-REQ -> completed ins_data is from mem_addr=0x004, not 0x008.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its optional I-cache.
// ICACHE_EN selects the cache build in instr_fetch_unit.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StFault
    } fetch_state_e;

    localparam logic [31:0] TextBaseDefault = 32'h0040_0000;

    localparam int unsigned CacheIdxW    = 2;
    localparam int unsigned CacheTagW    = 6;
    localparam int unsigned CacheEntries = 1 << CacheIdxW;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Datapath-side fetch handshake and instruction-memory read port of the fetch unit.
// The fetch unit connects through the master modport, its environment through slave.
interface instr_fetch_unit_if;

    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic [31:0] ins_data;
    logic        ins_valid;
    logic        stall;
    logic        fault;
    logic [9:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  cpu_addr, cpu_read, mem_ack, mem_rdata,
        output ins_data, ins_valid, stall, fault, mem_addr, mem_req
    );

    modport slave (
        output cpu_addr, cpu_read, mem_ack, mem_rdata,
        input  ins_data, ins_valid, stall, fault, mem_addr, mem_req
    );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: valid bits (reset-cleared), tags and data words.
// Lookup is combinational; a write fills one entry on the clock edge.
module icache_array
    import mips_fetch_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CacheIdxW-1:0] rd_idx,
    input  logic [CacheTagW-1:0] rd_tag,
    output logic                 rd_hit,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [CacheIdxW-1:0] wr_idx,
    input  logic [CacheTagW-1:0] wr_tag,
    input  logic [31:0]          wr_data
);

    logic [CacheEntries-1:0] valid_q;
    logic [CacheTagW-1:0]    tag_q  [CacheEntries];
    logic [31:0]             data_q [CacheEntries];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by valid_q.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: maps datapath byte addresses onto instruction memory and
// stalls the pipeline across misses. Define ICACHE_EN to add a 4-entry direct-mapped cache.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = TextBaseDefault,
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic                clock,
    input logic                reset,
    instr_fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [9:0]   mem_addr_q, mem_addr_d;
    logic [31:0]  ins_data_q, ins_data_d;
    logic [31:0]  offset;
    logic         illegal;
    logic         hit;
    logic [31:0]  hit_data;

    // Memory is indexed by byte offset from the start of .text.
    assign offset  = bus.cpu_addr - TEXT_BASE;
    assign illegal = (bus.cpu_addr < TEXT_BASE) || (offset >= MEM_WORDS) ||
                     (bus.cpu_addr[1:0] != 2'b00);

`ifdef ICACHE_EN
    logic fill;
    assign fill = (state_q == StReq) && bus.mem_ack;

    icache_array u_icache (
        .clock   (clock),
        .reset   (reset),
        .rd_idx  (offset[3:2]),
        .rd_tag  (offset[9:4]),
        .rd_hit  (hit),
        .rd_data (hit_data),
        .wr_en   (fill),
        .wr_idx  (mem_addr_q[3:2]),
        .wr_tag  (mem_addr_q[9:4]),
        .wr_data (bus.mem_rdata)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mem_addr_q <= '0;
            ins_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ins_data_q <= ins_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ins_data_d = ins_data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_read) begin
                    if (illegal) begin
                        state_d = StFault;
                    end else begin
                        mem_addr_d = offset[9:0];
                        if (hit) begin
                            ins_data_d = hit_data;
                            state_d    = StResp;
                        end else begin
                            state_d = StReq;
                        end
                    end
                end
            end
            StReq: begin
                if (bus.mem_ack) begin
                    ins_data_d = bus.mem_rdata;
                    state_d    = StResp;
                end
            end
            StResp:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the state register so reset takes effect without waiting for a clock.
    assign bus.mem_req   = (state_q == StReq);
    assign bus.ins_valid = (state_q == StResp);
    assign bus.fault     = (state_q == StFault);
    assign bus.stall     = (state_q == StReq) || (state_q == StFault) ||
                           ((state_q == StIdle) && bus.cpu_read);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.ins_data  = ins_data_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit: each fetch is turned into expected
// event windows (stall, mem_req, ins_valid, fault) from the latency rules and checked every cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] TEXT = 32'h0040_0000;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .TEXT_BASE (TEXT),
        .MEM_WORDS (1024)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [256];
    bit          cv [4];
    logic [5:0]  ct [4];

    // Expected event windows for the transaction in flight
    int          stall_lo = -10, stall_hi = -10;
    int          req_lo = 1, req_hi = 0;
    int          exp_valid_cyc = -10, exp_fault_cyc = -10;
    logic [31:0] exp_valid_data = '0;
    logic [9:0]  exp_mem_addr = '0;
    logic [31:0] model_data = '0;
    bit          chk_en = 1'b0;

    int          req_cnt = 0, fault_cnt = 0, last_valid_cyc = -1;
    logic [9:0]  last_req_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit cache_hit(input logic [9:0] off);
`ifdef ICACHE_EN
        return cv[off[3:2]] && (ct[off[3:2]] == off[9:4]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void cache_fill(input logic [9:0] off);
        cv[off[3:2]] = 1'b1;
        ct[off[3:2]] = off[9:4];
    endfunction

    function automatic void cache_clear();
        for (int i = 0; i < 4; i++) cv[i] = 1'b0;
    endfunction

    initial forever begin
        @(negedge clock);
        if (bus.mem_req) begin
            req_cnt++;
            last_req_addr = bus.mem_addr;
        end
        if (bus.fault) fault_cnt++;
        if (bus.ins_valid) last_valid_cyc = cyc;
        if (chk_en) begin
            if (cyc == exp_valid_cyc) model_data = exp_valid_data;
            chk("ins_valid", 32'(bus.ins_valid), 32'(cyc == exp_valid_cyc));
            chk("fault", 32'(bus.fault), 32'(cyc == exp_fault_cyc));
            chk("mem_req", 32'(bus.mem_req), 32'(cyc >= req_lo && cyc <= req_hi));
            chk("stall", 32'(bus.stall), 32'(cyc >= stall_lo && cyc <= stall_hi));
            chk("ins_data", bus.ins_data, model_data);
            if (cyc >= req_lo && cyc <= req_hi) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_mem_addr));
        end
    end

    // Issue one fetch while the unit is idle; mid != 0 forces cpu_addr while busy.
    task automatic fetch(input logic [31:0] addr, input int n, input logic [31:0] mid,
                         output int t0);
        logic [31:0] off;
        bit          bad, hit, in_req;
        int          last;
        off = addr - TEXT;
        bad = (addr < TEXT) || (off >= 32'd1024) || (addr[1:0] != 2'b00);
        hit = !bad && cache_hit(off[9:0]);
        t0  = cyc;
        bus.mem_ack  = 1'b0;
        bus.cpu_addr = addr;
        bus.cpu_read = 1'b1;
        stall_lo = t0;
        if (bad) begin
            exp_fault_cyc = t0 + 1;
            stall_hi      = t0 + 1;
            last          = t0 + 1;
        end else if (hit) begin
            exp_valid_cyc  = t0 + 1;
            exp_valid_data = mem_model[off[9:2]];
            stall_hi       = t0;
            last           = t0 + 1;
        end else begin
            req_lo         = t0 + 1;
            req_hi         = t0 + 1 + n;
            exp_mem_addr   = off[9:0];
            exp_valid_cyc  = t0 + 2 + n;
            exp_valid_data = mem_model[off[9:2]];
            stall_hi       = t0 + 1 + n;
            last           = t0 + 2 + n;
            cache_fill(off[9:0]);
        end
        while (cyc < last) begin
            @(posedge clock);
            #1;
            bus.cpu_read = 1'($urandom_range(0, 1));
            bus.cpu_addr = (mid != 0) ? mid : $urandom();
            in_req = !bad && !hit && (cyc <= t0 + 1 + n);
            bus.mem_ack   = in_req ? (cyc == t0 + 1 + n) : 1'($urandom_range(0, 1));
            bus.mem_rdata = (in_req && bus.mem_ack) ? mem_model[off[9:2]] : $urandom();
        end
        @(posedge clock);
        #1;
        bus.cpu_read = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        int          t0, r0, f0, n;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) mem_model[i] = $urandom();
        mem_model[0] = 32'h2408_0064;
        mem_model[1] = 32'h1111_0004;
        mem_model[2] = 32'h2222_0008;
        cache_clear();

        reset         = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_read  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #1;
        chk("rst_ins_data", bus.ins_data, 32'h0);
        chk("rst_ins_valid", 32'(bus.ins_valid), 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_stall_lo", 32'(bus.stall), 32'h0);
        bus.cpu_read = 1'b1;
        #1;
        chk("rst_stall_hi", 32'(bus.stall), 32'h1);
        bus.cpu_read = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // First miss, ack two cycles after mem_req rises
        fetch(TEXT, 2, 32'h0, t0);
        chk("miss_latency", 32'(last_valid_cyc - t0), 32'd4);
        chk("miss_data", bus.ins_data, 32'h2408_0064);
        chk("miss_addr", 32'(last_req_addr), 32'h0);

        // Refetch of the same word
        r0 = req_cnt;
        fetch(TEXT, 1, 32'h0, t0);
`ifdef ICACHE_EN
        chk("refetch_latency", 32'(last_valid_cyc - t0), 32'd1);
        chk("refetch_reqs", 32'(req_cnt - r0), 32'd0);
`else
        chk("refetch_latency", 32'(last_valid_cyc - t0), 32'd3);
        chk("refetch_reqs", 32'(req_cnt - r0), 32'd2);
`endif

        // Misaligned, below .text, past the end
        r0 = req_cnt;
        f0 = fault_cnt;
        fetch(32'h0040_0002, 0, 32'h0, t0);
        fetch(32'h003F_FFFC, 0, 32'h0, t0);
        fetch(32'h0040_0400, 0, 32'h0, t0);
        chk("fault_pulses", 32'(fault_cnt - f0), 32'd3);
        chk("fault_reqs", 32'(req_cnt - r0), 32'd0);
        chk("fault_data", bus.ins_data, 32'h2408_0064);

        // Address change while the request is outstanding
        fetch(32'h0040_0004, 1, 32'h0040_0008, t0);
        chk("midreq_data", bus.ins_data, 32'h1111_0004);
        chk("midreq_addr", 32'(last_req_addr), 32'h004);

        // Same-index conflict evicts the earlier line
        fetch(32'h0040_0010, 0, 32'h0, t0);
        r0 = req_cnt;
        fetch(TEXT, 0, 32'h0, t0);
        chk("evict_reqs", 32'(req_cnt - r0), 32'd1);
        chk("evict_addr", 32'(last_req_addr), 32'h0);
        chk("evict_data", bus.ins_data, 32'h2408_0064);

        // Reset while a request is outstanding
        chk_en       = 1'b0;
        bus.cpu_addr = 32'h0040_0020;
        bus.cpu_read = 1'b1;
        @(posedge clock);
        #1;
        bus.cpu_read = 1'b0;
        chk("pre_rst_req", 32'(bus.mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_mem_req", 32'(bus.mem_req), 32'h0);
        chk("async_ins_valid", 32'(bus.ins_valid), 32'h0);
        chk("async_stall", 32'(bus.stall), 32'h0);
        chk("async_ins_data", bus.ins_data, 32'h0);
        chk("async_mem_addr", 32'(bus.mem_addr), 32'h0);
        @(posedge clock);
        #1;
        bus.mem_ack = 1'b1;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        model_data = '0;
        cache_clear();
        stall_lo   = -10;
        stall_hi   = -10;
        chk_en     = 1'b1;
        @(posedge clock);
        #1;
        bus.mem_ack = 1'b0;
        chk("late_ack_data", bus.ins_data, 32'h0);
        r0 = req_cnt;
        fetch(TEXT, 1, 32'h0, t0);
        chk("post_rst_reqs", 32'(req_cnt - r0), 32'd2);
        chk("post_rst_latency", 32'(last_valid_cyc - t0), 32'd3);

        // Randomized traffic, biased toward a small working set to exercise hits
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0: a = TEXT + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
                1: a = TEXT - 4 * $urandom_range(1, 64);
                2: a = TEXT + 32'd1024 + 4 * $urandom_range(0, 64);
                3, 4, 5: a = TEXT + 4 * $urandom_range(0, 255);
                default: a = TEXT + 4 * $urandom_range(0, 15);
            endcase
            n = $urandom_range(0, 3);
            fetch(a, n, 32'h0, t0);
            repeat ($urandom_range(0, 2)) begin
                bus.mem_ack   = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom();
                @(posedge clock);
                #1;
            end
            bus.mem_ack = 1'b0;
        end

        @(posedge clock);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
